// File: rtl/regfile_arbiter_if.sv
// Bundle carrying both requester ports (A = UART command path, B = on-chip
// sequencer) and the single config-regfile access port.
// slave  : arbiter view.  master : requester/regfile environment view.
interface regfile_arbiter_if;
    logic       a_req, a_we;
    logic [7:0] a_addr, a_wdata;
    logic       a_gnt, a_rvalid, a_err;
    logic [7:0] a_rdata;

    logic       b_req, b_we;
    logic [7:0] b_addr, b_wdata;
    logic       b_gnt, b_rvalid, b_err;
    logic [7:0] b_rdata;

    logic       rf_write, rf_read;
    logic [7:0] rf_write_addr, rf_write_data, rf_read_addr;
    logic [7:0] rf_read_data;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  rf_read_data,
        output a_gnt, a_rvalid, a_err, a_rdata,
        output b_gnt, b_rvalid, b_err, b_rdata,
        output rf_write, rf_read, rf_write_addr, rf_write_data, rf_read_addr
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output rf_read_data,
        input  a_gnt, a_rvalid, a_err, a_rdata,
        input  b_gnt, b_rvalid, b_err, b_rdata,
        input  rf_write, rf_read, rf_write_addr, rf_write_data, rf_read_addr
    );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the single config regfile port between requester A
// (UART) and requester B (sequencer). One access in flight at a time:
//   IDLE -> ACCESS -> IDLE (write) | ACCESS -> CAPTURE -> IDLE (read).
// All outputs are registered. Out-of-range addresses (>= NUMREGS) never write
// the regfile and return 8'h00 with err.
// Optional feature macro ARB_LOCK_EN: b_lock sampled in IDLE gives B exclusive
// ownership; without the macro b_lock is ignored.
module regfile_arbiter #(
    parameter int NUMREGS   = 16,
    parameter int FIXED_PRI = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             b_lock,
    regfile_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

    localparam logic [8:0] ADDR_LIM = 9'(NUMREGS);

    state_t     state;
    logic       last_b;     // 1: B won the most recent unlocked grant
    logic       cmd_b;      // winner of the access in flight
    logic       cmd_we;
    logic       cmd_oor;

    logic       lock_on;
    logic       any_req;
    logic       pick_b;
    logic       sel_we;
    logic       sel_oor;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;

`ifdef ARB_LOCK_EN
    assign lock_on = b_lock;
`else
    logic unused_b_lock;
    assign unused_b_lock = b_lock;
    assign lock_on       = 1'b0;
`endif

    // Winner selection and command mux for the IDLE decision
    always_comb begin
        any_req = lock_on ? bus.b_req : (bus.a_req | bus.b_req);
        if (lock_on)
            pick_b = 1'b1;
        else if (bus.a_req && bus.b_req)
            pick_b = (FIXED_PRI == 0) && !last_b;
        else
            pick_b = bus.b_req;
        sel_we    = pick_b ? bus.b_we    : bus.a_we;
        sel_addr  = pick_b ? bus.b_addr  : bus.a_addr;
        sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
        sel_oor   = {1'b0, sel_addr} >= ADDR_LIM;
    end

    // Access FSM with registered handshake and regfile-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            last_b            <= 1'b1;
            cmd_b             <= 1'b0;
            cmd_we            <= 1'b0;
            cmd_oor           <= 1'b0;
            bus.a_gnt         <= 1'b0;
            bus.b_gnt         <= 1'b0;
            bus.a_rvalid      <= 1'b0;
            bus.b_rvalid      <= 1'b0;
            bus.a_err         <= 1'b0;
            bus.b_err         <= 1'b0;
            bus.a_rdata       <= 8'h00;
            bus.b_rdata       <= 8'h00;
            bus.rf_write      <= 1'b0;
            bus.rf_read       <= 1'b0;
            bus.rf_write_addr <= 8'h00;
            bus.rf_write_data <= 8'h00;
            bus.rf_read_addr  <= 8'h00;
        end else begin
            // handshake strobes are single-cycle pulses
            bus.a_gnt    <= 1'b0;
            bus.b_gnt    <= 1'b0;
            bus.a_rvalid <= 1'b0;
            bus.b_rvalid <= 1'b0;
            bus.a_err    <= 1'b0;
            bus.b_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state   <= ACCESS;
                        cmd_b   <= pick_b;
                        cmd_we  <= sel_we;
                        cmd_oor <= sel_oor;
                        // locked grants leave the round-robin pointer alone
                        if (!lock_on)
                            last_b <= pick_b;
                        if (pick_b) begin
                            bus.b_gnt <= 1'b1;
                            bus.b_err <= sel_we && sel_oor;
                        end else begin
                            bus.a_gnt <= 1'b1;
                            bus.a_err <= sel_we && sel_oor;
                        end
                        bus.rf_write      <= sel_we && !sel_oor;
                        bus.rf_read       <= !sel_we;
                        bus.rf_write_addr <= sel_addr;
                        bus.rf_write_data <= sel_wdata;
                        bus.rf_read_addr  <= sel_addr;
                    end
                end
                ACCESS: begin
                    if (cmd_we) begin
                        state             <= IDLE;
                        bus.rf_write      <= 1'b0;
                        bus.rf_write_addr <= 8'h00;
                        bus.rf_write_data <= 8'h00;
                        bus.rf_read_addr  <= 8'h00;
                    end else begin
                        state <= CAPTURE;   // rf_read and address stay up
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                    if (cmd_b) begin
                        bus.b_rdata  <= cmd_oor ? 8'h00 : bus.rf_read_data;
                        bus.b_rvalid <= 1'b1;
                        bus.b_err    <= cmd_oor;
                    end else begin
                        bus.a_rdata  <= cmd_oor ? 8'h00 : bus.rf_read_data;
                        bus.a_rvalid <= 1'b1;
                        bus.a_err    <= cmd_oor;
                    end
                    bus.rf_read       <= 1'b0;
                    bus.rf_write_addr <= 8'h00;
                    bus.rf_write_data <= 8'h00;
                    bus.rf_read_addr  <= 8'h00;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
